// File: rtl/nor_bus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : nor_bus_pkg                                                      |
// | Purpose : Shared definitions for the multi-chip NOR bus driver: FSM state  |
// |           encoding, default timing set and width helper functions.         |
// | Ports   : none (package)                                                   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package nor_bus_pkg;

  localparam int STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t RYWAIT = 3'd1;
  localparam state_t SETUP  = 3'd2;
  localparam state_t RDSTB  = 3'd3;
  localparam state_t WRSTB  = 3'd4;
  localparam state_t WRHOLD = 3'd5;
  localparam state_t DONE   = 3'd6;
  localparam state_t ERR    = 3'd7;

  // Default timing set, in clock cycles.
  localparam int DEF_TSETUP = 2;
  localparam int DEF_TRD    = 8;
  localparam int DEF_TWP    = 4;
  localparam int DEF_THOLD  = 2;
  localparam int DEF_RYTO   = 65535;

  // Chip-select field width; a single chip still gets a 1-bit field.
  function automatic int cs_bits(input int nchips);
    return (nchips <= 2) ? 1 : $clog2(nchips);
  endfunction

  function automatic int max_of5(input int a, input int b, input int c,
                                 input int d, input int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nor_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : nor_timer                                                        |
// | Purpose : Loadable down-counter with terminal-count flag. Stops at zero.   |
// | Ports   : clk    - clock                                                   |
// |           rst_n  - synchronous reset, active-low                           |
// |           load   - load 'value' this edge (wins over counting)             |
// |           value  - reload value (count of remaining cycles minus one)      |
// |           tc     - high while the count is zero                            |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module nor_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n)
      count <= '0;
    else if (load)
      count <= value;
    else if (count != '0)
      count <= count - 1'b1;
  end

  assign tc = (count == '0);

endmodule
`default_nettype wire

// File: rtl/nor_bus_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : nor_bus_mc                                                       |
// | Purpose : Pipelined Wishbone slave driving up to NCHIPS parallel NOR       |
// |           devices with shared address/data/WE#/OE# and per-chip CE#/RY.    |
// |           Waits on the selected chip's RY with a timeout reported as err.  |
// | Ports   : wb_clk_i/wb_rst_i     - clock, sync active-low reset            |
// |           wb_adr_i             - {chip index, word address}               |
// |           wb_dat_i/wb_we_i     - write data / write enable                |
// |           wb_stb_i/wb_cyc_i    - strobe / cycle                           |
// |           wb_ack_o/wb_err_o    - one-cycle completion / error pulses      |
// |           wb_stall_o           - high whenever a request is outstanding   |
// |           wb_dat_o             - last captured read data                  |
// |           nor_ry_i             - per-chip RY/BY# (1 = ready)              |
// |           nor_data_i/_o/_oe    - NOR data bus in, out, drive enable       |
// |           nor_addr_o           - shared word address                      |
// |           nor_ce_o/we_o/oe_o   - active-low chip enables and strobes      |
// |           timeout_o            - sticky RY timeout flag                   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module nor_bus_mc
  import nor_bus_pkg::*;
#(
  parameter int ADDRBITS = 26,
  parameter int DATABITS = 16,
  parameter int NCHIPS   = 2,
  parameter int CSBITS   = cs_bits(NCHIPS),
  parameter int TSETUP   = DEF_TSETUP,
  parameter int TRD      = DEF_TRD,
  parameter int TWP      = DEF_TWP,
  parameter int THOLD    = DEF_THOLD,
  parameter int RYTO     = DEF_RYTO
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic [ADDRBITS+CSBITS-1:0] wb_adr_i,
  input  logic [DATABITS-1:0]        wb_dat_i,
  input  logic                       wb_we_i,
  input  logic                       wb_stb_i,
  input  logic                       wb_cyc_i,
  output logic                       wb_ack_o,
  output logic                       wb_err_o,
  output logic                       wb_stall_o,
  output logic [DATABITS-1:0]        wb_dat_o,
  input  logic [NCHIPS-1:0]          nor_ry_i,
  input  logic [DATABITS-1:0]        nor_data_i,
  output logic [DATABITS-1:0]        nor_data_o,
  output logic [ADDRBITS-1:0]        nor_addr_o,
  output logic [NCHIPS-1:0]          nor_ce_o,
  output logic                       nor_we_o,
  output logic                       nor_oe_o,
  output logic                       nor_data_oe,
  output logic                       timeout_o
);

  localparam int CNTW = $clog2(max_of5(TSETUP, TRD, TWP, THOLD, RYTO) + 1);

  state_t              state;
  state_t              next_state;
  logic [CSBITS-1:0]   req_sel;
  logic [ADDRBITS-1:0] req_addr;
  logic [DATABITS-1:0] req_data;
  logic                req_we;
  logic                accept;
  logic                bad_chip;
  logic                ry_sel;
  logic [2**CSBITS-1:0] ry_pad;
  logic                tmr_load;
  logic [CNTW-1:0]     tmr_value;
  logic                tmr_tc;
  logic                busy;

  assign accept   = wb_cyc_i & wb_stb_i & (state == IDLE);
  assign bad_chip = (32'(wb_adr_i[ADDRBITS +: CSBITS]) >= NCHIPS);

  // Pad RY out to the full select range so an index never leaves the vector.
  always_comb begin
    ry_pad             = '0;
    ry_pad[NCHIPS-1:0] = nor_ry_i;
  end
  assign ry_sel = ry_pad[req_sel];

  // One timer serves every phase: it is reloaded on each state change with
  // the length of the phase being entered (RY timeout while in RYWAIT).
  assign tmr_load = (next_state != state);

  always_comb begin
    tmr_value = '0;
    case (next_state)
      RYWAIT:  tmr_value = CNTW'(RYTO - 1);
      SETUP:   tmr_value = CNTW'(TSETUP - 1);
      RDSTB:   tmr_value = CNTW'(TRD - 1);
      WRSTB:   tmr_value = CNTW'(TWP - 1);
      WRHOLD:  tmr_value = CNTW'(THOLD - 1);
      default: tmr_value = '0;
    endcase
  end

  nor_timer #(
    .WIDTH (CNTW)
  ) u_timer (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_i),
    .load  (tmr_load),
    .value (tmr_value),
    .tc    (tmr_tc)
  );

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i)
      state <= IDLE;
    else
      state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = bad_chip ? ERR : RYWAIT;
      RYWAIT:  if (ry_sel) next_state = SETUP;
               else if (tmr_tc) next_state = ERR;
      SETUP:   if (tmr_tc) next_state = req_we ? WRSTB : RDSTB;
      RDSTB:   if (tmr_tc) next_state = DONE;
      WRSTB:   if (tmr_tc) next_state = WRHOLD;
      WRHOLD:  if (tmr_tc) next_state = DONE;
      DONE:    next_state = IDLE;
      ERR:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
    // Master abandoned the cycle: release everything, no response.
    if ((state != IDLE) && !wb_cyc_i)
      next_state = IDLE;
  end

  // Outputs decoded from the current state.
  always_comb begin
    busy        = (state == RYWAIT) || (state == SETUP) || (state == RDSTB) ||
                  (state == WRSTB)  || (state == WRHOLD);
    wb_stall_o  = (state != IDLE);
    wb_ack_o    = (state == DONE) && wb_cyc_i;
    wb_err_o    = (state == ERR)  && wb_cyc_i;
    nor_oe_o    = !(state == RDSTB);
    nor_we_o    = !(state == WRSTB);
    nor_data_oe = req_we && ((state == SETUP) || (state == WRSTB) || (state == WRHOLD));
    nor_addr_o  = req_addr;
    nor_data_o  = req_data;
    nor_ce_o    = '1;
    for (int i = 0; i < NCHIPS; i++)
      if (busy && (req_sel == CSBITS'(i)))
        nor_ce_o[i] = 1'b0;
  end

  // Request latch, read-data capture and sticky timeout flag.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      req_sel   <= '0;
      req_addr  <= '0;
      req_data  <= '0;
      req_we    <= 1'b0;
      wb_dat_o  <= '0;
      timeout_o <= 1'b0;
    end else begin
      // A bad chip index never reaches the pins, so leave the latches alone.
      if (accept && !bad_chip) begin
        req_sel  <= wb_adr_i[ADDRBITS +: CSBITS];
        req_addr <= wb_adr_i[ADDRBITS-1:0];
        req_data <= wb_dat_i;
        req_we   <= wb_we_i;
      end
      if ((state == RDSTB) && tmr_tc)
        wb_dat_o <= nor_data_i;
      if ((state == RYWAIT) && !ry_sel && tmr_tc)
        timeout_o <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nor_bus_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_nor_bus_mc                                                    |
// | Purpose : Self-checking bench for nor_bus_mc. Instance A uses the default  |
// |           two-chip build; instance B is a three-chip build with RYTO=50.   |
// |           Expected responses are queued at issue and popped on ack/err.    |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_nor_bus_mc;

  typedef struct {
    logic        is_err;
    logic [15:0] data;
    logic        chk_data;
  } resp_t;

  resp_t sb[$];
  resp_t exp_r;

  int n_chk  = 0;
  int n_fail = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] dat = '0;
  logic        we = 1'b0;
  logic [15:0] ndin = 16'h5A5A;

  // Instance A signals.
  logic [26:0] adr_a = '0;
  logic        cyc_a = 1'b0, stb_a = 1'b0;
  logic [1:0]  ry_a = 2'b11;
  logic        ack_a, err_a, stall_a, nwe_a, noe_a, doe_a, to_a;
  logic [15:0] rdat_a, nd_o_a;
  logic [25:0] naddr_a;
  logic [1:0]  ce_a;

  // Instance B signals.
  logic [27:0] adr_b = '0;
  logic        cyc_b = 1'b0, stb_b = 1'b0;
  logic [2:0]  ry_b = 3'b111;
  logic        ack_b, err_b, stall_b, nwe_b, noe_b, doe_b, to_b;
  logic [15:0] rdat_b, nd_o_b;
  logic [25:0] naddr_b;
  logic [2:0]  ce_b;

  // Observations gathered by watch_a.
  int          ack_at, err_at, oe_cnt, oe_first, we_cnt, we_last;
  int          doe_first, doe_last, ce_low_cnt, viol;
  logic [1:0]  ce_first;
  logic [15:0] resp_dat;

  always #5 clk = ~clk;

  nor_bus_mc #(.NCHIPS(2)) dut_a (
    .wb_clk_i (clk), .wb_rst_i (rst_n), .wb_adr_i (adr_a), .wb_dat_i (dat),
    .wb_we_i (we), .wb_stb_i (stb_a), .wb_cyc_i (cyc_a), .wb_ack_o (ack_a),
    .wb_err_o (err_a), .wb_stall_o (stall_a), .wb_dat_o (rdat_a),
    .nor_ry_i (ry_a), .nor_data_i (ndin), .nor_data_o (nd_o_a),
    .nor_addr_o (naddr_a), .nor_ce_o (ce_a), .nor_we_o (nwe_a),
    .nor_oe_o (noe_a), .nor_data_oe (doe_a), .timeout_o (to_a)
  );

  nor_bus_mc #(.NCHIPS(3), .RYTO(50)) dut_b (
    .wb_clk_i (clk), .wb_rst_i (rst_n), .wb_adr_i (adr_b), .wb_dat_i (dat),
    .wb_we_i (we), .wb_stb_i (stb_b), .wb_cyc_i (cyc_b), .wb_ack_o (ack_b),
    .wb_err_o (err_b), .wb_stall_o (stall_b), .wb_dat_o (rdat_b),
    .nor_ry_i (ry_b), .nor_data_i (ndin), .nor_data_o (nd_o_b),
    .nor_addr_o (naddr_b), .nor_ce_o (ce_b), .nor_we_o (nwe_b),
    .nor_oe_o (noe_b), .nor_data_oe (doe_b), .timeout_o (to_b)
  );

  // Cycle 0 is the cycle whose closing edge accepts the request; returns
  // #1 after the edge that opens cycle 1.
  task automatic issue_a(input logic [26:0] a, input logic [15:0] d, input logic w);
    @(posedge clk); #1;
    adr_a = a; dat = d; we = w; cyc_a = 1'b1; stb_a = 1'b1;
    @(posedge clk); #1;
    stb_a = 1'b0;
  endtask

  task automatic issue_b(input logic [27:0] a);
    @(posedge clk); #1;
    adr_b = a; we = 1'b0; cyc_b = 1'b1; stb_b = 1'b1;
    @(posedge clk); #1;
    stb_b = 1'b0;
  endtask

  // Steps instance A through cycles 1..limit, recording pin activity and
  // stopping after the first ack/err. nor_data_i carries 'good' only in
  // cycle rd_cyc; RY goes high at ry_hi_at; cyc drops at drop_at.
  task automatic watch_a(input int limit, input int rd_cyc, input logic [15:0] good,
                         input int ry_hi_at, input int drop_at,
                         input logic [25:0] exp_addr, input logic [15:0] exp_dat);
    ack_at = -1; err_at = -1; oe_cnt = 0; oe_first = -1; we_cnt = 0; we_last = -1;
    doe_first = -1; doe_last = -1; ce_low_cnt = 0; viol = 0; ce_first = 2'b11;
    resp_dat = '0;
    for (int n = 1; n <= limit; n++) begin
      if (n == ry_hi_at) ry_a = 2'b11;
      if (n == drop_at) cyc_a = 1'b0;
      ndin = (n == rd_cyc) ? good : 16'h5A5A;
      @(negedge clk);
      if (n == 1) ce_first = ce_a;
      if (ce_a != 2'b11) ce_low_cnt++;
      if (!noe_a) begin oe_cnt++; if (oe_first < 0) oe_first = n; end
      if (!nwe_a) begin we_cnt++; we_last = n; end
      if (doe_a) begin if (doe_first < 0) doe_first = n; doe_last = n; end
      if ((!nwe_a && !noe_a) || (!noe_a && doe_a) || (ce_a == 2'b00) ||
          (ce_a != 2'b11 && naddr_a !== exp_addr) || (doe_a && nd_o_a !== exp_dat))
        viol++;
      if (ack_a && ack_at < 0) begin ack_at = n; resp_dat = rdat_a; end
      if (err_a && err_at < 0) err_at = n;
      @(posedge clk); #1;
      if (ack_at > 0 || err_at > 0) break;
    end
    ndin = 16'h5A5A;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({ack_a, err_a, stall_a, to_a, nwe_a, noe_a, doe_a} !== 7'b0000110) begin
      n_fail++; $display("FAIL reset_a_ctl: got %b exp 0000110", {ack_a, err_a, stall_a, to_a, nwe_a, noe_a, doe_a});
    end
    n_chk++;
    if (ce_a !== 2'b11) begin n_fail++; $display("FAIL reset_a_ce: got %b exp 11", ce_a); end
    n_chk++;
    if ({rdat_a, nd_o_a, naddr_a} !== 58'd0) begin
      n_fail++; $display("FAIL reset_a_data: rdat %h ndo %h addr %h exp all 0", rdat_a, nd_o_a, naddr_a);
    end
    n_chk++;
    if ({ce_b, ack_b, err_b, stall_b, to_b, nwe_b, noe_b, doe_b} !== 10'b111_0000110) begin
      n_fail++; $display("FAIL reset_b: got %b exp 1110000110", {ce_b, ack_b, err_b, stall_b, to_b, nwe_b, noe_b, doe_b});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_read;
    ry_a = 2'b11;
    sb.push_back('{1'b0, 16'hBEEF, 1'b1});
    issue_a({1'b1, 26'h0001234}, 16'h0000, 1'b0);
    watch_a(30, 11, 16'hBEEF, -1, -1, 26'h0001234, 16'h0000);
    cyc_a = 1'b0;
    n_chk++;
    if (ce_first !== 2'b01) begin n_fail++; $display("FAIL rd_ce: got %b exp 01", ce_first); end
    n_chk++;
    if (oe_cnt !== 8 || oe_first !== 4) begin
      n_fail++; $display("FAIL rd_oe: low %0d cycles from %0d, exp 8 from 4", oe_cnt, oe_first);
    end
    n_chk++;
    if (ack_at !== 12) begin n_fail++; $display("FAIL rd_ack_cycle: got %0d exp 12", ack_at); end
    n_chk++;
    if (viol !== 0 || we_cnt !== 0) begin
      n_fail++; $display("FAIL rd_pins: violations %0d we_low %0d exp 0 0", viol, we_cnt);
    end
    n_chk++;
    if (ack_at < 0 && err_at < 0) begin
      n_fail++; $display("FAIL rd_resp: no response within budget");
    end else begin
      exp_r = sb.pop_front();
      if ((err_at > 0) !== exp_r.is_err || (exp_r.chk_data && resp_dat !== exp_r.data)) begin
        n_fail++; $display("FAIL rd_resp: err %0d data %h exp err %0d data %h", err_at > 0, resp_dat, exp_r.is_err, exp_r.data);
      end
    end
  endtask

  task automatic test_write;
    ry_a = 2'b11;
    sb.push_back('{1'b0, 16'h0000, 1'b0});
    issue_a({1'b0, 26'h0000AAA}, 16'h00AA, 1'b1);
    watch_a(30, -1, 16'h0000, -1, -1, 26'h0000AAA, 16'h00AA);
    cyc_a = 1'b0;
    n_chk++;
    if (ce_first !== 2'b10) begin n_fail++; $display("FAIL wr_ce: got %b exp 10", ce_first); end
    n_chk++;
    if (doe_first !== 2 || doe_last !== 9) begin
      n_fail++; $display("FAIL wr_data_oe: cycles %0d..%0d exp 2..9", doe_first, doe_last);
    end
    n_chk++;
    if (we_cnt !== 4 || we_last !== 7) begin
      n_fail++; $display("FAIL wr_we: low %0d cycles ending %0d, exp 4 ending 7", we_cnt, we_last);
    end
    n_chk++;
    if (doe_last - we_last !== 2) begin
      n_fail++; $display("FAIL wr_hold: %0d cycles after WE rise exp 2", doe_last - we_last);
    end
    n_chk++;
    if (oe_cnt !== 0 || viol !== 0) begin
      n_fail++; $display("FAIL wr_pins: oe_low %0d violations %0d exp 0 0", oe_cnt, viol);
    end
    n_chk++;
    if (ack_at !== 10) begin n_fail++; $display("FAIL wr_ack_cycle: got %0d exp 10", ack_at); end
    n_chk++;
    if (ack_at < 0 && err_at < 0) begin
      n_fail++; $display("FAIL wr_resp: no response within budget");
    end else begin
      exp_r = sb.pop_front();
      if ((err_at > 0) !== exp_r.is_err) begin
        n_fail++; $display("FAIL wr_resp: err %0d exp %0d", err_at > 0, exp_r.is_err);
      end
    end
  endtask

  task automatic test_ry_wait;
    ry_a = 2'b10;
    sb.push_back('{1'b0, 16'h4242, 1'b1});
    issue_a({1'b0, 26'h0000042}, 16'h0000, 1'b0);
    watch_a(200, 111, 16'h4242, 101, -1, 26'h0000042, 16'h0000);
    cyc_a = 1'b0;
    n_chk++;
    if (ack_at !== 112) begin n_fail++; $display("FAIL ry_ack_cycle: got %0d exp 112", ack_at); end
    n_chk++;
    if (to_a !== 1'b0) begin n_fail++; $display("FAIL ry_timeout: got %b exp 0", to_a); end
    n_chk++;
    if (ack_at < 0 && err_at < 0) begin
      n_fail++; $display("FAIL ry_resp: no response within budget");
    end else begin
      exp_r = sb.pop_front();
      if ((err_at > 0) !== exp_r.is_err || resp_dat !== exp_r.data) begin
        n_fail++; $display("FAIL ry_resp: err %0d data %h exp err %0d data %h", err_at > 0, resp_dat, exp_r.is_err, exp_r.data);
      end
    end
  endtask

  task automatic test_timeout;
    int ack_cnt;
    int e_at;
    logic [2:0] ce1;
    ack_cnt = 0; e_at = -1; ce1 = 3'b111;
    ry_b = 3'b101;
    sb.push_back('{1'b1, 16'h0000, 1'b0});
    issue_b({2'd1, 26'h0000321});
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (n == 1) ce1 = ce_b;
      if (ack_b) ack_cnt++;
      if (err_b && e_at < 0) e_at = n;
      @(posedge clk); #1;
      if (e_at > 0) break;
    end
    cyc_b = 1'b0;
    @(negedge clk);
    n_chk++;
    if (ce1 !== 3'b101) begin n_fail++; $display("FAIL to_ce: got %b exp 101", ce1); end
    n_chk++;
    if (e_at !== 51) begin n_fail++; $display("FAIL to_err_cycle: got %0d exp 51", e_at); end
    n_chk++;
    if (to_b !== 1'b1 || ack_cnt !== 0) begin
      n_fail++; $display("FAIL to_flag: timeout %b acks %0d exp 1 0", to_b, ack_cnt);
    end
    n_chk++;
    if ({ce_b, nwe_b, noe_b, doe_b} !== 6'b111110) begin
      n_fail++; $display("FAIL to_release: got %b exp 111110", {ce_b, nwe_b, noe_b, doe_b});
    end
    n_chk++;
    if (e_at < 0) begin
      n_fail++; $display("FAIL to_resp: no response within budget");
    end else begin
      exp_r = sb.pop_front();
      if (exp_r.is_err !== 1'b1 || ack_cnt !== 0) begin
        n_fail++; $display("FAIL to_resp: kind err=%b acks %0d", exp_r.is_err, ack_cnt);
      end
    end
    ry_b = 3'b111;
  endtask

  task automatic test_bad_chip;
    int e_at;
    int e_cnt;
    int ce_act;
    e_at = -1; e_cnt = 0; ce_act = 0;
    issue_b({2'd3, 26'h0000555});
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      if (ce_b !== 3'b111 || !nwe_b || !noe_b) ce_act++;
      if (err_b) begin e_cnt++; if (e_at < 0) e_at = n; end
      @(posedge clk); #1;
    end
    cyc_b = 1'b0;
    n_chk++;
    if (e_at !== 1 || e_cnt !== 1) begin
      n_fail++; $display("FAIL bad_err: first %0d count %0d exp 1 1", e_at, e_cnt);
    end
    n_chk++;
    if (ce_act !== 0) begin n_fail++; $display("FAIL bad_pins: %0d active cycles exp 0", ce_act); end
  endtask

  task automatic test_cyc_drop;
    ry_a = 2'b11;
    issue_a({1'b0, 26'h0000077}, 16'h1234, 1'b1);
    watch_a(8, -1, 16'h0000, -1, 5, 26'h0000077, 16'h1234);
    n_chk++;
    if (we_last !== 5 || we_cnt !== 2) begin
      n_fail++; $display("FAIL drop_we: low %0d cycles ending %0d exp 2 ending 5", we_cnt, we_last);
    end
    n_chk++;
    if (ack_at !== -1 || err_at !== -1 || sb.size() !== 0) begin
      n_fail++; $display("FAIL drop_resp: ack %0d err %0d queued %0d exp none", ack_at, err_at, sb.size());
    end
    n_chk++;
    if (doe_last !== 5 || stall_a !== 1'b0) begin
      n_fail++; $display("FAIL drop_release: data_oe until %0d stall %b exp 5 0", doe_last, stall_a);
    end
    // The next request runs normally.
    sb.push_back('{1'b0, 16'h1357, 1'b1});
    issue_a({1'b0, 26'h0000100}, 16'h0000, 1'b0);
    watch_a(30, 11, 16'h1357, -1, -1, 26'h0000100, 16'h0000);
    cyc_a = 1'b0;
    n_chk++;
    if (ack_at !== 12 || viol !== 0) begin
      n_fail++; $display("FAIL drop_next_cycle: ack %0d violations %0d exp 12 0", ack_at, viol);
    end
    n_chk++;
    if (ack_at < 0 && err_at < 0) begin
      n_fail++; $display("FAIL drop_next_resp: no response within budget");
    end else begin
      exp_r = sb.pop_front();
      if ((err_at > 0) !== exp_r.is_err || resp_dat !== exp_r.data) begin
        n_fail++; $display("FAIL drop_next_resp: data %h exp %h", resp_dat, exp_r.data);
      end
    end
  endtask

  task automatic test_reset_mid;
    ry_a = 2'b11;
    issue_a({1'b1, 26'h0000777}, 16'h0000, 1'b0);
    watch_a(6, -1, 16'h0000, -1, -1, 26'h0000777, 16'h0000);
    n_chk++;
    if (oe_cnt !== 3) begin n_fail++; $display("FAIL rst_mid_oe: got %0d exp 3", oe_cnt); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; cyc_a = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({ack_a, err_a, stall_a, nwe_a, noe_a, doe_a, ce_a} !== 8'b00011011) begin
      n_fail++; $display("FAIL rst_mid_ctl: got %b exp 00011011", {ack_a, err_a, stall_a, nwe_a, noe_a, doe_a, ce_a});
    end
    n_chk++;
    if ({rdat_a, naddr_a, nd_o_a} !== 58'd0) begin
      n_fail++; $display("FAIL rst_mid_data: rdat %h addr %h ndo %h exp 0", rdat_a, naddr_a, nd_o_a);
    end
    sb.push_back('{1'b0, 16'hC0DE, 1'b1});
    issue_a({1'b1, 26'h0000778}, 16'h0000, 1'b0);
    watch_a(30, 11, 16'hC0DE, -1, -1, 26'h0000778, 16'h0000);
    cyc_a = 1'b0;
    n_chk++;
    if (ack_at !== 12) begin n_fail++; $display("FAIL rst_next_cycle: got %0d exp 12", ack_at); end
    n_chk++;
    if (ack_at < 0 && err_at < 0) begin
      n_fail++; $display("FAIL rst_next_resp: no response within budget");
    end else begin
      exp_r = sb.pop_front();
      if ((err_at > 0) !== exp_r.is_err || resp_dat !== exp_r.data) begin
        n_fail++; $display("FAIL rst_next_resp: data %h exp %h", resp_dat, exp_r.data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_ry_wait();
    test_timeout();
    test_bad_chip();
    test_cyc_drop();
    test_reset_mid();
    n_chk++;
    if (sb.size() !== 0) begin n_fail++; $display("FAIL sb_drain: %0d left exp 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
